// File: rtl/term_text_buf.sv
// term_text_buf: character store and cursor engine for the VGA text terminal.
// Define TERM_CURSOR_EN to overlay a blinking '_' cursor on the character fetch.
module term_text_buf #(
  parameter int TERM_W            = 70,
  parameter int TERM_H            = 30,
  parameter int CURSOR_BLINK_LOG2 = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic [11:0] rd_idx,
  output logic [7:0]  rd_char,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col
);

  localparam int CELLS = TERM_W * TERM_H;
  localparam logic [11:0] N         = 12'(CELLS);
  localparam logic [11:0] W         = 12'(TERM_W);
  localparam logic [11:0] INIT_LAST = 12'(CELLS - 1);
  localparam logic [11:0] CLR_LAST  = 12'(TERM_W - 1);
  localparam logic [6:0]  LAST_COL  = 7'(TERM_W - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(TERM_H - 1);

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  state_t      state, state_n;
  logic [11:0] clear_ptr, clear_ptr_n;
  logic [11:0] clear_base, clear_base_n;
  logic [11:0] top_off, top_off_n;
  logic [4:0]  row_n;
  logic [6:0]  col_n;
  logic        accept, wrap;
  logic        we;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic [11:0] cur_cell;
  logic [7:0]  ram_q;
  logic [7:0]  mem [CELLS];

  // logical cell -> physical RAM address through the circular top offset
  function automatic logic [11:0] phys(input logic [11:0] l,
                                       input logic [11:0] off);
    logic [12:0] s;
    s = {1'b0, l} + {1'b0, off};
    if (s >= {1'b0, N}) s = s - {1'b0, N};
    return s[11:0];
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign cur_cell = 12'(cur_row) * W + 12'(cur_col);

  // state, cursor and scroll registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      clear_ptr  <= '0;
      clear_base <= '0;
      top_off    <= '0;
      cur_row    <= '0;
      cur_col    <= '0;
    end else begin
      state      <= state_n;
      clear_ptr  <= clear_ptr_n;
      clear_base <= clear_base_n;
      top_off    <= top_off_n;
      cur_row    <= row_n;
      cur_col    <= col_n;
    end
  end

  // byte interpretation, fill sequencing and write-port steering
  always_comb begin
    state_n      = state;
    clear_ptr_n  = clear_ptr;
    clear_base_n = clear_base;
    top_off_n    = top_off;
    row_n        = cur_row;
    col_n        = cur_col;
    wrap         = 1'b0;
    we           = 1'b0;
    waddr        = clear_ptr;
    wdata        = 8'h20;
    unique case (state)
      INIT: begin
        we          = 1'b1;
        waddr       = clear_ptr;
        clear_ptr_n = clear_ptr + 12'd1;
        if (clear_ptr == INIT_LAST) begin
          clear_ptr_n = '0;
          state_n     = IDLE;
        end
      end
      CLEAR: begin
        we          = 1'b1;
        waddr       = clear_base + clear_ptr;
        clear_ptr_n = clear_ptr + 12'd1;
        if (clear_ptr == CLR_LAST) begin
          clear_ptr_n = '0;
          state_n     = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (in_char >= 8'h20 && in_char <= 8'h7E): begin
              we    = 1'b1;
              waddr = phys(cur_cell, top_off);
              wdata = in_char;
              if (cur_col < LAST_COL) begin
                col_n = cur_col + 7'd1;
              end else begin
                col_n = '0;
                wrap  = 1'b1;
              end
            end
            (in_char == 8'h0A): begin
              col_n = '0;
              wrap  = 1'b1;
            end
            (in_char == 8'h0D): col_n = '0;
            (in_char == 8'h08): begin
              if (cur_col != '0) begin
                col_n = cur_col - 7'd1;
                we    = 1'b1;
                waddr = phys(cur_cell - 12'd1, top_off);
              end
            end
            default: ;
          endcase
          if (wrap) begin
            if (cur_row < LAST_ROW) begin
              row_n = cur_row + 5'd1;
            end else begin
              clear_base_n = top_off;
              top_off_n    = (top_off == N - W) ? '0 : top_off + W;
              clear_ptr_n  = '0;
              state_n      = CLEAR;
            end
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  // character RAM write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered character fetch; out-of-range cells read as blank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_q <= 8'h20;
    end else if (rd_idx >= N) begin
      ram_q <= 8'h20;
    end else begin
      ram_q <= mem[phys(rd_idx, top_off)];
    end
  end

`ifdef TERM_CURSOR_EN
  logic [CURSOR_BLINK_LOG2-1:0] blink_cnt;
  logic                         phase;
  logic [11:0]                  rd_idx_q;

  // blink timebase and fetch-address pipeline for the overlay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
      rd_idx_q  <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) phase <= ~phase;
      rd_idx_q  <= rd_idx;
    end
  end

  assign rd_char = (phase && state == IDLE && rd_idx_q == cur_cell)
                 ? 8'h5F : ram_q;
`else
  assign rd_char = ram_q;
`endif

endmodule
